// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param; the FIFO takes the slave side and the
// producer/consumer takes the master side.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             clr_err;
  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, wr, data_in, rd,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow,
           underflow
  );

  modport slave (
    input  flush, clr_err, wr, data_in, rd,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow,
           underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read, occupancy
// thresholds, flush and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = 56,
  parameter int unsigned AE_LEVEL = 8,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave fifo_if
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             empty, full, rd_ok, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  // Flush swallows both requests; a write at full only lands alongside an accepted read.
  assign rd_ok = fifo_if.rd & ~empty & ~fifo_if.flush;
  assign wr_ok = fifo_if.wr & (~full | rd_ok) & ~fifo_if.flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    ovf_d      = (ovf_q & ~fifo_if.clr_err) | (fifo_if.wr & ~wr_ok & ~fifo_if.flush);
    udf_d      = (udf_q & ~fifo_if.clr_err) | (fifo_if.rd & ~rd_ok & ~fifo_if.flush);
    if (fifo_if.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      data_d  = '0;
    end else begin
      if (wr_ok) head_d = head_q + 1'b1;
      if (rd_ok) begin
        tail_d     = tail_q + 1'b1;
        data_d     = mem_q[tail_q];
        rd_valid_d = 1'b1;
      end
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[head_q] <= fifo_if.data_in;
  end

  assign fifo_if.data_out     = (FWFT != 0) ? (empty ? '0 : mem_q[tail_q]) : data_q;
  assign fifo_if.rd_valid     = (FWFT != 0) ? ~empty : rd_valid_q;
  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign fifo_if.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_if.count        = count_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance plus a FWFT instance.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int   mcount;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) fi ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) ff ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .fifo_if (fi)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut_fwft (
    .clk     (clk),
    .reset   (reset),
    .fifo_if (ff)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    {fi.flush, fi.clr_err, fi.wr, fi.rd} = '0;
    {ff.flush, ff.clr_err, ff.wr, ff.rd} = '0;
    fi.data_in = '0;
    ff.data_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(fi.count), 0);
    check("rst_empty", 32'(fi.empty), 1);
    check("rst_full", 32'(fi.full), 0);
    check("rst_ae", 32'(fi.almost_empty), 1);
    check("rst_af", 32'(fi.almost_full), 0);
    check("rst_dout", 32'(fi.data_out), 0);
    check("rst_rdv", 32'(fi.rd_valid), 0);
    check("rst_ovf", 32'(fi.overflow), 0);
    check("rst_udf", 32'(fi.underflow), 0);

    // 5: FWFT display and pop
    check("fw_rdv0", 32'(ff.rd_valid), 0);
    ff.wr = 1'b1; ff.data_in = 8'h3C;
    tick();
    ff.wr = 1'b0;
    check("fw_dout", 32'(ff.data_out), 32'h3C);
    check("fw_rdv", 32'(ff.rd_valid), 1);
    tick();
    check("fw_hold", 32'(ff.data_out), 32'h3C);
    ff.rd = 1'b1;
    tick();
    ff.rd = 1'b0;
    check("fw_empty", 32'(ff.empty), 1);
    check("fw_dout0", 32'(ff.data_out), 0);
    check("fw_rdv1", 32'(ff.rd_valid), 0);

    // 1: fill 0x01..0x10 then drain
    for (int i = 1; i <= 16; i++) begin
      fi.wr = 1'b1; fi.data_in = 8'(i);
      tick();
      check("t1_count", 32'(fi.count), 32'(i));
      if (i == 2 || i == 3) check("t1_ae", 32'(fi.almost_empty), (i == 2) ? 1 : 0);
      if (i == 13 || i == 14) check("t1_af", 32'(fi.almost_full), (i == 14) ? 1 : 0);
      if (i == 15 || i == 16) check("t1_full", 32'(fi.full), (i == 16) ? 1 : 0);
    end
    fi.wr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      fi.rd = 1'b1;
      tick();
      check("t1_rd", 32'(fi.data_out), 32'(i));
      check("t1_rdv", 32'(fi.rd_valid), 1);
    end
    fi.rd = 1'b0;
    check("t1_empty", 32'(fi.empty), 1);
    tick();
    check("t1_rdv0", 32'(fi.rd_valid), 0);
    check("t1_hold", 32'(fi.data_out), 32'h10);

    // 2: overflow at full, concurrent rd/wr at full
    for (int i = 0; i < 16; i++) begin
      fi.wr = 1'b1; fi.data_in = 8'(8'h21 + i);
      tick();
    end
    fi.data_in = 8'hAA;
    tick();
    check("t2_ovf", 32'(fi.overflow), 1);
    check("t2_cnt16", 32'(fi.count), 16);
    fi.data_in = 8'hBB; fi.rd = 1'b1;
    tick();
    fi.wr = 1'b0;
    check("t2_cnt_rw", 32'(fi.count), 16);
    check("t2_old", 32'(fi.data_out), 32'h21);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t2_rd", 32'(fi.data_out), (k < 15) ? 32'(8'h22 + k) : 32'hBB);
    end
    fi.rd = 1'b0;
    check("t2_ovf_held", 32'(fi.overflow), 1);
    fi.clr_err = 1'b1;
    tick();
    fi.clr_err = 1'b0;
    check("t2_clr", 32'(fi.overflow), 0);

    // 3: underflow, read+write on empty
    fi.rd = 1'b1;
    tick();
    check("t3_udf", 32'(fi.underflow), 1);
    check("t3_rdv", 32'(fi.rd_valid), 0);
    fi.wr = 1'b1; fi.data_in = 8'h55;
    tick();
    {fi.wr, fi.rd} = '0;
    check("t3_cnt", 32'(fi.count), 1);
    fi.clr_err = 1'b1;
    tick();
    fi.clr_err = 1'b0;
    check("t3_clr", 32'(fi.underflow), 0);
    fi.rd = 1'b1;
    tick();
    fi.rd = 1'b0;
    check("t3_data", 32'(fi.data_out), 32'h55);
    check("t3_cnt0", 32'(fi.count), 0);

    // 4: alternating bursts with scoreboard
    mcount = 0;
    for (int c = 0; c < 40; c++) begin
      if ((c % 8) < 5) begin
        fi.wr = 1'b1; fi.rd = 1'b0; fi.data_in = 8'(c * 7 + 3);
      end else begin
        fi.wr = 1'b0; fi.rd = 1'b1;
      end
      tick();
      if (fi.wr) begin
        sb.push_back(fi.data_in);
        mcount++;
      end else begin
        exp_b = sb.pop_front();
        mcount--;
        check("t4_data", 32'(fi.data_out), 32'(exp_b));
        check("t4_rdv", 32'(fi.rd_valid), 1);
      end
      check("t4_count", 32'(fi.count), 32'(mcount));
    end
    {fi.wr, fi.rd} = '0;

    // 6: bring to count 9 with overflow set, then flush and reset mid-burst
    for (int i = 0; i < 6; i++) begin
      fi.wr = 1'b1; fi.data_in = 8'(8'hC0 + i);
      sb.push_back(fi.data_in);
      tick();
    end
    fi.data_in = 8'hEE;
    tick();
    fi.wr = 1'b0;
    check("t6_ovf", 32'(fi.overflow), 1);
    for (int i = 0; i < 7; i++) begin
      fi.rd = 1'b1;
      tick();
      exp_b = sb.pop_front();
      check("t6_rd", 32'(fi.data_out), 32'(exp_b));
    end
    check("t6_cnt9", 32'(fi.count), 9);
    fi.flush = 1'b1; fi.wr = 1'b1; fi.data_in = 8'h99;
    tick();
    fi.flush = 1'b0;
    check("t6_fl_cnt", 32'(fi.count), 0);
    check("t6_fl_empty", 32'(fi.empty), 1);
    check("t6_fl_rdv", 32'(fi.rd_valid), 0);
    check("t6_fl_dout", 32'(fi.data_out), 0);
    check("t6_fl_ovf", 32'(fi.overflow), 1);
    check("t6_fl_udf", 32'(fi.underflow), 0);
    fi.rd = 1'b0;
    fi.data_in = 8'h12;
    tick();
    tick();
    check("t6_cnt2", 32'(fi.count), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; fi.wr = 1'b0;
    check("t6_rs_cnt", 32'(fi.count), 0);
    check("t6_rs_empty", 32'(fi.empty), 1);
    check("t6_rs_rdv", 32'(fi.rd_valid), 0);
    check("t6_rs_ovf", 32'(fi.overflow), 0);
    fi.wr = 1'b1; fi.data_in = 8'h77;
    tick();
    fi.wr = 1'b0; fi.rd = 1'b1;
    tick();
    fi.rd = 1'b0;
    check("t6_77", 32'(fi.data_out), 32'h77);
    check("t6_77v", 32'(fi.rd_valid), 1);
    check("t6_end", 32'(fi.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
